// File: rtl/qpd_sweep_sequencer.sv
// rtl/qpd_sweep_sequencer.sv - quarter-period-delay trigger sequencer over a delay/average sweep
// Optional acquisition-ack timeout is enabled by defining QPD_SEQ_TIMEOUT_EN.
module qpd_sweep_sequencer #(
  parameter int DELAY_W        = 8,
  parameter int POINT_W        = 8,
  parameter int AVG_W          = 8,
  parameter int TIMEOUT_CYCLES = 100000
) (
  input  logic               sclock,
  input  logic               rst_n,
  input  logic               start,
  input  logic               abort,
  input  logic               rt,
  input  logic [DELAY_W-1:0] delay_start,
  input  logic [DELAY_W-1:0] delay_step,
  input  logic [POINT_W-1:0] num_points,
  input  logic [AVG_W-1:0]   num_avg,
  input  logic               acq_done,
  output logic               trigger,
  output logic [DELAY_W-1:0] cur_delay,
  output logic [POINT_W-1:0] point_idx,
  output logic [AVG_W-1:0]   avg_idx,
  output logic               busy,
  output logic               done,
  output logic               err
);

  typedef enum logic [2:0] {
    S_IDLE, S_ARM, S_DELAY, S_FIRE, S_WAIT_ACK, S_NEXT, S_DONE
  } state_t;

  state_t             state, state_nx;
  logic               rt_d;
  logic               rt_edge, delay_hit, avg_more, pt_more, to_hit;
  logic [DELAY_W-1:0] step_r, dcnt;
  logic [POINT_W-1:0] npts_r;
  logic [AVG_W-1:0]   navg_r;

  assign rt_edge   = rt & ~rt_d;
  // Compare one ahead so FIRE lands exactly cur_delay cycles after the edge cycle's successor.
  assign delay_hit = (dcnt + DELAY_W'(1)) == cur_delay;
  assign avg_more  = (avg_idx + AVG_W'(1)) != navg_r;
  assign pt_more   = (point_idx + POINT_W'(1)) != npts_r;

  assign trigger = (state == S_FIRE) && !abort;
  assign done    = (state == S_DONE) && !abort;
  assign busy    = (state != S_IDLE);

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:     if (start) state_nx = (num_points == '0 || num_avg == '0) ? S_DONE : S_ARM;
      S_ARM:      if (rt_edge) state_nx = (cur_delay == '0) ? S_FIRE : S_DELAY;
      S_DELAY:    if (delay_hit) state_nx = S_FIRE;
      S_FIRE:     state_nx = S_WAIT_ACK;
      S_WAIT_ACK: begin
        if (acq_done)    state_nx = S_NEXT;
        else if (to_hit) state_nx = S_IDLE;
      end
      S_NEXT:     state_nx = (avg_more || pt_more) ? S_ARM : S_DONE;
      S_DONE:     state_nx = S_IDLE;
      default:    state_nx = S_IDLE;
    endcase
    if (abort) state_nx = S_IDLE;
  end

  always_ff @(posedge sclock or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      rt_d      <= 1'b0;
      step_r    <= '0;
      dcnt      <= '0;
      npts_r    <= '0;
      navg_r    <= '0;
      cur_delay <= '0;
      point_idx <= '0;
      avg_idx   <= '0;
    end else begin
      state <= state_nx;
      rt_d  <= rt;
      if (!abort) begin
        case (state)
          S_IDLE: if (start) begin
            step_r    <= delay_step;
            npts_r    <= num_points;
            navg_r    <= num_avg;
            cur_delay <= delay_start;
            point_idx <= '0;
            avg_idx   <= '0;
          end
          S_ARM:   if (rt_edge) dcnt <= '0;
          S_DELAY: dcnt <= dcnt + DELAY_W'(1);
          S_NEXT: begin
            if (avg_more) begin
              avg_idx <= avg_idx + AVG_W'(1);
            end else if (pt_more) begin
              avg_idx   <= '0;
              point_idx <= point_idx + POINT_W'(1);
              cur_delay <= cur_delay + step_r;
            end
          end
          default: ;
        endcase
      end
    end
  end

`ifdef QPD_SEQ_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [TO_W-1:0] to_cnt;
  logic            err_r;

  assign to_hit = (to_cnt == TO_W'(TIMEOUT_CYCLES - 1));
  assign err    = err_r;

  always_ff @(posedge sclock or negedge rst_n) begin
    if (!rst_n) begin
      to_cnt <= '0;
      err_r  <= 1'b0;
    end else if (!abort) begin
      if (state == S_IDLE && start) err_r <= 1'b0;
      if (state == S_FIRE) begin
        to_cnt <= '0;
      end else if (state == S_WAIT_ACK && !acq_done) begin
        if (to_hit) err_r  <= 1'b1;
        else        to_cnt <= to_cnt + TO_W'(1);
      end
    end
  end
`else
  assign to_hit = 1'b0;
  assign err    = 1'b0;
`endif

endmodule

// File: tb/tb_qpd_sweep_sequencer.sv
// tb/tb_qpd_sweep_sequencer.sv - directed and randomized sweeps against a sweep-level reference model
module tb_qpd_sweep_sequencer;

  logic       sclock = 1'b0;
  logic       rst_n = 1'b0, start = 1'b0, abort = 1'b0, rt = 1'b0, acq_done = 1'b0;
  logic [7:0] delay_start = '0, delay_step = '0, num_points = '0, num_avg = '0;
  logic       trigger, busy, done, err;
  logic [7:0] cur_delay, point_idx, avg_idx;
  int         n_cmp = 0, n_bad = 0;

  always #5 sclock = ~sclock;

  qpd_sweep_sequencer #(
    .DELAY_W(8), .POINT_W(8), .AVG_W(8), .TIMEOUT_CYCLES(10)
  ) dut (
    .sclock(sclock), .rst_n(rst_n), .start(start), .abort(abort), .rt(rt),
    .delay_start(delay_start), .delay_step(delay_step), .num_points(num_points),
    .num_avg(num_avg), .acq_done(acq_done), .trigger(trigger), .cur_delay(cur_delay),
    .point_idx(point_idx), .avg_idx(avg_idx), .busy(busy), .done(done), .err(err)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic adv();
    @(posedge sclock);
    #1;
  endtask

  task automatic smp();
    @(negedge sclock);
  endtask

  // One trigger of the sweep: expected delay d at point p, average a.
  task automatic one_shot(input int d, input int p, input int a, input bit last);
    int gap, w;
    gap = $urandom_range(1, 3);
    for (int g = 0; g < gap; g++) begin
      acq_done = 1'($urandom_range(0, 1));
      smp(); chk("arm_quiet", 32'({trigger, done, busy}), 1); adv();
    end
    acq_done = 1'b0;
    rt = 1'b1;
    smp(); chk("edge_cycle_trig", 32'(trigger), 0); adv();
    for (int k = 1; k <= d + 1; k++) begin
      if (k == 2) rt = 1'b0;
      start    = (k == 1) ? 1'($urandom_range(0, 1)) : 1'b0;
      acq_done = (k <= d) ? 1'($urandom_range(0, 1)) : 1'b0;
      smp();
      if (k == d + 1) begin
        chk("trig_at_offset", 32'(trigger), 1);
        chk("cur_delay", 32'(cur_delay), 32'(d));
        chk("point_idx", 32'(point_idx), 32'(p));
        chk("avg_idx", 32'(avg_idx), 32'(a));
      end else begin
        chk("trig_early", 32'(trigger), 0);
      end
      adv();
    end
    start = 1'b0; rt = 1'b0; acq_done = 1'b0;
    w = $urandom_range(0, 4);
    for (int k = 0; k < w; k++) begin
      rt = (k == 1);
      smp(); chk("wait_ack_quiet", 32'({trigger, done, busy}), 1); adv();
    end
    rt = 1'b0;
    acq_done = 1'b1;
    smp(); chk("ack_cycle", 32'({trigger, done, busy}), 1); adv();
    acq_done = 1'b0;
    smp(); chk("next_cycle", 32'({trigger, done, busy}), 1); adv();
    if (last) begin
      smp(); chk("done_pulse", 32'({trigger, done, busy, err}), 32'b0110); adv();
      smp(); chk("after_done", 32'({trigger, done, busy}), 0); adv();
    end
  endtask

  // Reference: point p uses (delay_start + p*delay_step) mod 256, each repeated num_avg times.
  task automatic run_sweep(input int ds, input int st, input int np, input int na);
    delay_start = 8'(ds); delay_step = 8'(st); num_points = 8'(np); num_avg = 8'(na);
    start = 1'b1;
    smp(); chk("start_idle", 32'(busy), 0); adv();
    start = 1'b0;
    delay_start = 8'($urandom); delay_step = 8'($urandom);
    num_points = 8'($urandom); num_avg = 8'($urandom);
    if (np == 0 || na == 0) begin
      smp(); chk("zero_done", 32'({trigger, done, busy}), 32'b011);
      chk("zero_cur_delay", 32'(cur_delay), 32'(ds)); adv();
      smp(); chk("zero_after", 32'({trigger, done, busy}), 0); adv();
      return;
    end
    for (int p = 0; p < np; p++)
      for (int a = 0; a < na; a++)
        one_shot((ds + p * st) % 256, p, a, (p == np - 1) && (a == na - 1));
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    repeat (2) adv();
    smp(); chk("reset_outputs", 32'({trigger, busy, done, err, cur_delay, point_idx, avg_idx}), 0); adv();
    rst_n = 1'b1;
    adv();

    run_sweep(5, 0, 1, 1);
    run_sweep(2, 3, 3, 2);
    run_sweep(254, 3, 2, 1);
    run_sweep(9, 1, 0, 2);
    run_sweep(9, 1, 2, 0);

    // abort in DELAY with counter at 3
    delay_start = 8'd6; delay_step = 8'd0; num_points = 8'd1; num_avg = 8'd1;
    start = 1'b1; adv(); start = 1'b0; adv();
    rt = 1'b1; adv(); rt = 1'b0;
    repeat (3) adv();
    abort = 1'b1;
    smp(); chk("abort_trig", 32'({trigger, done}), 0); adv();
    abort = 1'b0;
    smp(); chk("abort_idle", 32'(busy), 0); chk("abort_hold", 32'(cur_delay), 6); adv();
    for (int i = 0; i < 10; i++) begin
      rt = (i == 3);
      smp(); chk("post_abort_quiet", 32'({trigger, done, busy}), 0); adv();
    end
    rt = 1'b0;

    // abort and start together
    start = 1'b1; abort = 1'b1; adv(); start = 1'b0; abort = 1'b0;
    smp(); chk("abort_beats_start", 32'(busy), 0); adv();

    for (int i = 0; i < 6; i++)
      run_sweep($urandom_range(0, 255), $urandom_range(0, 255), $urandom_range(1, 3), $urandom_range(1, 3));

    // async reset mid-DELAY
    delay_start = 8'd20; delay_step = 8'd1; num_points = 8'd2; num_avg = 8'd2;
    start = 1'b1; adv(); start = 1'b0; adv();
    rt = 1'b1; adv(); rt = 1'b0;
    repeat (4) adv();
    #2 rst_n = 1'b0;
    #1 chk("async_reset", 32'({trigger, busy, done, err, cur_delay, point_idx, avg_idx}), 0);
    adv(); adv();
    rst_n = 1'b1;
    smp(); chk("reset_release_idle", 32'({busy, done, trigger}), 0); adv();

`ifdef QPD_SEQ_TIMEOUT_EN
    delay_start = 8'd1; delay_step = 8'd0; num_points = 8'd1; num_avg = 8'd1;
    start = 1'b1; adv(); start = 1'b0;
    rt = 1'b1; adv();
    rt = 1'b0;
    smp(); chk("to_trig_early", 32'(trigger), 0); adv();
    smp(); chk("to_trig", 32'(trigger), 1); adv();
    for (int i = 0; i < 10; i++) begin
      smp(); chk("to_waiting", 32'({busy, done, err}), 32'b100); adv();
    end
    smp(); chk("to_expired", 32'({busy, done, err}), 32'b001); adv();
    start = 1'b1; adv(); start = 1'b0;
    smp(); chk("to_err_cleared", 32'({busy, err}), 32'b10); adv();
    abort = 1'b1; adv(); abort = 1'b0;
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
